// File: rtl/fetch_buffer.sv
// Instruction queue between the fetch aligner and decode: holds {pc, instr} pairs,
// classifies RVC words, and presents the head entry to decode via valid/ready.
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_instr_i,
  output logic        if_ready_o,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_rvc_o,
  output logic [31:0] id_pc_next_o
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [31:0]      w_head_pc;
  logic [31:0]      w_head_instr;
  logic             w_rvc;

  assign if_ready_o = (r_count != CNT_W'(DEPTH));
  assign id_valid_o = (r_count != '0);

  assign w_push = if_valid_i & if_ready_o & ~flush_i;
  assign w_pop  = id_valid_o & id_ready_i & ~flush_i;

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  // Pointer and occupancy state; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: empty-buffer outputs are masked below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= if_pc_i;
      r_instr_mem[r_wr_ptr] <= if_instr_i;
    end
  end

  assign w_head_pc    = r_pc_mem[r_rd_ptr];
  assign w_head_instr = r_instr_mem[r_rd_ptr];
  assign w_rvc        = id_valid_o & (w_head_instr[1:0] != 2'b11);

  // Head presentation; an empty buffer shows pc=0, instr=0, full-width, next=4.
  always_comb begin
    id_pc_o    = '0;
    id_instr_o = '0;
    if (id_valid_o) begin
      id_pc_o    = w_head_pc;
      id_instr_o = w_rvc ? {16'h0000, w_head_instr[15:0]} : w_head_instr;
    end
  end

  assign id_rvc_o     = w_rvc;
  assign id_pc_next_o = id_pc_o + (w_rvc ? 32'd2 : 32'd4);

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_instr_i;
  logic        if_ready_o;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_rvc_o;
  logic [31:0] id_pc_next_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mq[$];  // reference model: {pc, instr}, front is head

  fetch_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
    .if_ready_o(if_ready_o), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_instr_o(id_instr_o), .id_rvc_o(id_rvc_o),
    .id_pc_next_o(id_pc_next_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs from a negedge, advance the model at the posedge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    logic push, pop;
    if_valid_i = v; if_pc_i = pc; if_instr_i = ins; id_ready_i = rdy; flush_i = fl;
    push = v && (mq.size() != 2) && !fl;
    pop  = (mq.size() != 0) && rdy && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({pc, ins});
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_tests++;
    if ({id_valid_o, if_ready_o, id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o} !==
        {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h4}) begin
      n_fail++;
      $display("FAIL reset_state: v=%0b r=%0b pc=%h ins=%h rvc=%0b nxt=%h, want v=0 r=1 pc=0 ins=0 rvc=0 nxt=4",
               id_valid_o, if_ready_o, id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o);
    end
  endtask

  task automatic test_full_instr;
    drive(1'b1, 32'h100, 32'h00A00093, 1'b0, 1'b0);
    n_tests++;
    if ({id_valid_o, id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o} !==
        {1'b1, 32'h100, 32'h00A00093, 1'b0, 32'h104}) begin
      n_fail++;
      $display("FAIL full_instr: v=%0b pc=%h ins=%h rvc=%0b nxt=%h, want 1 100 00a00093 0 104",
               id_valid_o, id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_rvc;
    drive(1'b1, 32'h202, 32'hDEAD4505, 1'b0, 1'b0);
    n_tests++;
    if ({id_valid_o, id_instr_o, id_rvc_o, id_pc_next_o} !== {1'b1, 32'h00004505, 1'b1, 32'h204}) begin
      n_fail++;
      $display("FAIL rvc: v=%0b ins=%h rvc=%0b nxt=%h, want 1 00004505 1 204",
               id_valid_o, id_instr_o, id_rvc_o, id_pc_next_o);
    end
    drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
    n_tests++;
    if ({id_pc_o, id_rvc_o, id_pc_next_o} !== {32'hFFFF_FFFE, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h rvc=%0b nxt=%h, want fffffffe 1 00000000", id_pc_o, id_rvc_o, id_pc_next_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h300, 32'h00000013, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'h00100013, 1'b0, 1'b0);
    n_tests++;
    if (if_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full_ready: got %0b want 0", if_ready_o);
    end
    drive(1'b1, 32'h308, 32'h00200013, 1'b0, 1'b0);   // held upstream
    n_tests++;
    if ({id_valid_o, if_ready_o, id_pc_o} !== {1'b1, 1'b0, 32'h300}) begin
      n_fail++; $display("FAIL b2b_hold: v=%0b r=%0b pc=%h want 1 0 300", id_valid_o, if_ready_o, id_pc_o);
    end
    drive(1'b1, 32'h308, 32'h00200013, 1'b1, 1'b0);   // pop only, push blocked while full
    n_tests++;
    if ({id_pc_o, if_ready_o} !== {32'h304, 1'b1}) begin
      n_fail++; $display("FAIL b2b_pop1: pc=%h r=%0b want 304 1", id_pc_o, if_ready_o);
    end
    drive(1'b1, 32'h308, 32'h00200013, 1'b1, 1'b0);
    n_tests++;
    if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, 32'h308, 32'h00200013}) begin
      n_fail++; $display("FAIL b2b_wrap: v=%0b pc=%h ins=%h want 1 308 00200013", id_valid_o, id_pc_o, id_instr_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (id_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: v=%0b want 0", id_valid_o);
    end
  endtask

  task automatic test_stream;
    logic [31:0] pc;
    pc = 32'h400;
    drive(1'b1, pc, 32'h00000013, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, pc + 32'd4, 32'h00000013, 1'b1, 1'b0);
      pc = pc + 32'd4;
      n_tests++;
      if ({id_valid_o, if_ready_o, id_pc_o} !== {1'b1, 1'b1, pc}) begin
        n_fail++;
        $display("FAIL stream[%0d]: v=%0b r=%0b pc=%h want 1 1 %h", i, id_valid_o, if_ready_o, id_pc_o, pc);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_full;
    drive(1'b1, 32'h500, 32'h00000013, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 32'h00000013, 1'b0, 1'b0);
    drive(1'b1, 32'h600, 32'h00000013, 1'b1, 1'b1);
    n_tests++;
    if ({id_valid_o, if_ready_o} !== {1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flush: v=%0b r=%0b want 0 1", id_valid_o, if_ready_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (id_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_write: v=%0b want 0", id_valid_o);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h700, 32'h00000013, 1'b0, 1'b0);
    drive(1'b1, 32'h704, 32'h00000013, 1'b0, 1'b0);
    if_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({id_valid_o, if_ready_o} !== {1'b0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: v=%0b r=%0b want 0 1", id_valid_o, if_ready_o);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] epc, eins, enxt;
    logic erv;
    for (int i = 0; i < 400; i++) begin
      n_tests++;
      if (id_valid_o !== (mq.size() != 0) || if_ready_o !== (mq.size() != 2)) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: v=%0b r=%0b want v=%0b r=%0b", i, id_valid_o, if_ready_o,
                 mq.size() != 0, mq.size() != 2);
      end else if (mq.size() != 0) begin
        epc  = mq[0][63:32];
        erv  = (mq[0][1:0] != 2'b11);
        eins = erv ? {16'h0, mq[0][15:0]} : mq[0][31:0];
        enxt = epc + (erv ? 32'd2 : 32'd4);
        if ({id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o} !== {epc, eins, erv, enxt}) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: pc=%h ins=%h rvc=%0b nxt=%h want %h %h %0b %h", i,
                   id_pc_o, id_instr_o, id_rvc_o, id_pc_next_o, epc, eins, erv, enxt);
        end
      end
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : ($urandom() & 32'hFFFF_FFFE),
            $urandom(),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; id_ready_i = 1'b0;
    if_pc_i = '0; if_instr_i = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_full_instr;
    test_rvc;
    test_back_to_back;
    test_stream;
    test_flush_full;
    test_async_reset;
    test_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
